// File: rtl/fenwick_sched_pkg.sv
// Shared constants for the FENWICK front-end scheduler.
// Command codes, index width and FSM encoding.
package fenwick_sched_pkg;

  localparam int IDX_W = 3;

  localparam logic [1:0] FW_UPD  = 2'b00;
  localparam logic [1:0] FW_QSET = 2'b11;
  localparam logic [1:0] FW_QRD  = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE,
    S_UPD,
    S_QSET,
    S_QRD
  } state_t;

endpackage

// File: rtl/fenwick_sched_arb.sv
// Two-way round-robin grant; the last winner yields
// on conflict and is only updated when advance is high.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last;

  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      req == 2'b11: grant = last ? 2'b01 : 2'b10;
      req == 2'b01: grant = 2'b01;
      req == 2'b10: grant = 2'b10;
      default:      grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last <= 1'b1;
    end else if (advance) begin
      last <= grant[1];
    end
  end

endmodule

// File: rtl/fenwick_sched.sv
// Shares one FENWICK XOR-tree between two requesters,
// sequencing updates and two-cycle queries.
module fenwick_sched
  import fenwick_sched_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [1:0]         req_op,
  input  logic [2*IDX_W-1:0] req_idx,
  input  logic [1:0]         req_val,
  output logic [1:0]         rsp_valid,
  output logic               rsp_data,
  output logic [1:0]         fw_inst,
  output logic [IDX_W-1:0]   fw_idx,
  output logic               fw_val,
  input  logic               fw_rangexor
);

  state_t state, nxt;

  logic [1:0]       grant;
  logic             issue;
  logic             accept;
  logic             sel;
  logic             id;
  logic             sel_op;
  logic             sel_val;
  logic [IDX_W-1:0] sel_idx;

  // Every state except QSET ends an operation.
  assign issue     = state != S_QSET;
  assign req_ready = issue ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign sel       = req_ready[1];
  assign sel_op    = req_op[sel];
  assign sel_val   = req_val[sel];
  assign sel_idx   = sel ? req_idx[2*IDX_W-1:IDX_W]
                         : req_idx[IDX_W-1:0];

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .advance (accept),
    .grant   (grant)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = S_IDLE;
    unique case (1'b1)
      !issue: nxt = S_QRD;
      accept: nxt = sel_op ? S_QSET : S_UPD;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fw_inst   <= FW_UPD;
      fw_idx    <= '0;
      fw_val    <= 1'b0;
      id        <= 1'b0;
      rsp_valid <= 2'b00;
      rsp_data  <= 1'b0;
    end else begin
      rsp_valid <= 2'b00;
      if (state == S_QRD) begin
        rsp_valid <= id ? 2'b10 : 2'b01;
        rsp_data  <= fw_rangexor;
      end
      unique case (1'b1)
        accept: begin
          fw_inst <= sel_op ? FW_QSET : FW_UPD;
          fw_idx  <= sel_idx;
          fw_val  <= sel_val;
          id      <= sel;
        end
        state == S_QSET: fw_inst <= FW_QRD;
        default: begin
          fw_inst <= FW_UPD;
          fw_idx  <= '0;
          fw_val  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fenwick_sched.sv
// Bench for fenwick_sched: FENWICK stand-in, cycle-indexed
// expectation model, directed scenarios and random traffic.
module tb_fenwick_sched;
  import fenwick_sched_pkg::*;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [1:0]         req_valid = '0;
  logic [1:0]         req_ready;
  logic [1:0]         req_op = '0;
  logic [2*IDX_W-1:0] req_idx = '0;
  logic [1:0]         req_val = '0;
  logic [1:0]         rsp_valid;
  logic               rsp_data;
  logic [1:0]         fw_inst;
  logic [IDX_W-1:0]   fw_idx;
  logic               fw_val;
  logic               fw_rangexor = 1'b0;

  fenwick_sched dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_idx     (req_idx),
    .req_val     (req_val),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .fw_inst     (fw_inst),
    .fw_idx      (fw_idx),
    .fw_val      (fw_val),
    .fw_rangexor (fw_rangexor)
  );

  always #5 clk = ~clk;

  // FENWICK stand-in: result valid only from QSET through QRD.
  bit fmem [8];
  always @(negedge clk) begin
    if (fw_inst == 2'b00) begin
      fmem[fw_idx] = fmem[fw_idx] ^ fw_val;
      fw_rangexor = 1'($urandom);
    end else if (fw_inst == 2'b11) begin
      fw_rangexor = 1'b0;
      for (int i = 0; i <= int'(fw_idx); i++)
        fw_rangexor = fw_rangexor ^ fmem[i];
    end
  end

  typedef struct packed {
    logic [1:0]       inst;
    logic [IDX_W-1:0] idx;
    logic             val;
    logic [1:0]       rv;
    logic             rd;
  } exp_t;

  exp_t       ex [int];
  int         cyc = 0;
  int         next_issue = 0;
  int         mlast = 1;
  bit         mmem [8];
  bit         m_acc;
  int         m_who;
  logic [1:0] exp_ready;
  int         n_vec = 0;
  int         n_miss = 0;
  logic [1:0] last_rv;
  logic       last_rd;
  int         grants [$];
  logic [1:0] inst_log [$];

  function automatic bit prefix(int k);
    bit x = 1'b0;
    for (int i = 0; i <= k; i++) x = x ^ mmem[i];
    return x;
  endfunction

  function automatic exp_t get_ex(int k);
    return ex.exists(k) ? ex[k] : exp_t'(0);
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exv);
    n_vec++;
    if (act !== exv) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exv, cyc);
    end
  endtask

  task automatic model_reset();
    ex.delete();
    next_issue = cyc;
    mlast = 1;
  endtask

  task automatic predict();
    m_acc = 1'b0;
    m_who = 0;
    exp_ready = 2'b00;
    if (reset && cyc >= next_issue && req_valid != 2'b00) begin
      if (req_valid == 2'b11) m_who = (mlast == 1) ? 0 : 1;
      else m_who = req_valid[1] ? 1 : 0;
      m_acc = 1'b1;
      exp_ready[m_who] = 1'b1;
    end
  endtask

  task automatic compare();
    exp_t e;
    e = get_ex(cyc);
    chk("fw_inst", 32'(fw_inst), 32'(e.inst));
    chk("fw_idx", 32'(fw_idx), 32'(e.idx));
    chk("fw_val", 32'(fw_val), 32'(e.val));
    chk("rsp_valid", 32'(rsp_valid), 32'(e.rv));
    if (e.rv != 2'b00) chk("rsp_data", 32'(rsp_data), 32'(e.rd));
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    if (rsp_valid != 2'b00) begin
      last_rv = rsp_valid;
      last_rd = rsp_data;
    end
    inst_log.push_back(fw_inst);
    ex.delete(cyc);
  endtask

  task automatic commit();
    exp_t e;
    int   ix;
    logic op;
    logic v;
    if (!(reset && m_acc)) return;
    op = req_op[m_who];
    v  = req_val[m_who];
    ix = int'(req_idx[m_who*IDX_W +: IDX_W]);
    mlast = m_who;
    grants.push_back(m_who);
    e = get_ex(cyc + 1);
    e.inst = op ? 2'b11 : 2'b00;
    e.idx = IDX_W'(ix);
    e.val = v;
    ex[cyc + 1] = e;
    if (!op) begin
      mmem[ix] = mmem[ix] ^ v;
      next_issue = cyc + 1;
    end else begin
      e = get_ex(cyc + 2);
      e.inst = 2'b01;
      e.idx = IDX_W'(ix);
      e.val = v;
      ex[cyc + 2] = e;
      e = get_ex(cyc + 3);
      e.rv = (m_who == 1) ? 2'b10 : 2'b01;
      e.rd = prefix(ix);
      ex[cyc + 3] = e;
      next_issue = cyc + 2;
    end
  endtask

  task automatic step();
    @(negedge clk);
    predict();
    compare();
    @(posedge clk);
    commit();
    cyc++;
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic set_cmd(int r, bit op, int ix, bit v);
    req_op[r] = op;
    req_val[r] = v;
    req_idx[r*IDX_W +: IDX_W] = IDX_W'(ix);
    req_valid[r] = 1'b1;
  endtask

  task automatic send(int r, bit op, int ix, bit v);
    bit got = 1'b0;
    set_cmd(r, op, ix, v);
    for (int i = 0; i < 12 && !got; i++) begin
      step();
      got = m_acc && (m_who == r);
    end
    chk("send_accept", 32'(got), 32'd1);
    req_valid[r] = 1'b0;
  endtask

  initial begin
    last_rv = '0;
    last_rd = 1'b0;
    idle(2);
    reset = 1'b1;

    // Reset during QSET drops the query.
    send(0, 1'b1, 5, 1'b0);
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst_inst", 32'(fw_inst), 32'd0);
    chk("rst_idx", 32'(fw_idx), 32'd0);
    chk("rst_val", 32'(fw_val), 32'd0);
    chk("rst_rv", 32'(rsp_valid), 32'd0);
    chk("rst_rd", 32'(rsp_data), 32'd0);
    idle(3);
    reset = 1'b1;
    last_rv = '0;
    idle(5);
    chk("rst_norsp", 32'(last_rv), 32'd0);
    chk("rst_after", 32'(fw_inst), 32'd0);

    // Update, update, query back to back.
    inst_log.delete();
    send(0, 1'b0, 0, 1'b1);
    send(0, 1'b0, 4, 1'b1);
    send(0, 1'b1, 7, 1'b0);
    idle(4);
    chk("seq0", 32'(inst_log[1]), 32'd0);
    chk("seq1", 32'(inst_log[2]), 32'd0);
    chk("seq2", 32'(inst_log[3]), 32'd3);
    chk("seq3", 32'(inst_log[4]), 32'd1);
    chk("q7_rv", 32'(last_rv), 32'd1);
    chk("q7_rd", 32'(last_rd), 32'd0);

    last_rv = '0;
    send(1, 1'b1, 3, 1'b0);
    idle(3);
    chk("q3_rv", 32'(last_rv), 32'd2);
    chk("q3_rd", 32'(last_rd), 32'd1);
    send(0, 1'b0, 5, 1'b1);
    send(0, 1'b0, 6, 1'b1);
    last_rv = '0;
    send(1, 1'b1, 7, 1'b0);
    idle(3);
    chk("q7b_rv", 32'(last_rv), 32'd2);
    chk("q7b_rd", 32'(last_rd), 32'd0);

    // Both requesters hold queries: grants alternate.
    idle(2);
    grants.delete();
    set_cmd(0, 1'b1, 6, 1'b0);
    set_cmd(1, 1'b1, 2, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step();
      if (m_acc) set_cmd(m_who, 1'b1, $urandom_range(0, 7), 1'b0);
    end
    req_valid = 2'b00;
    idle(4);
    chk("alt_n", 32'(grants.size()), 32'd4);
    for (int i = 0; i < grants.size() && i < 4; i++)
      chk("alt_g", 32'(grants[i]), 32'(i % 2));

    // Update accepted in the QRD slot overlaps the response.
    send(1, 1'b1, 2, 1'b0);
    set_cmd(0, 1'b0, 1, 1'b1);
    step();
    step();
    chk("ovl_acc", 32'(m_acc && m_who == 0), 32'd1);
    req_valid = 2'b00;
    chk("ovl_rv", 32'(rsp_valid), 32'd2);
    chk("ovl_inst", 32'(fw_inst), 32'd0);
    chk("ovl_val", 32'(fw_val), 32'd1);
    chk("ovl_idx", 32'(fw_idx), 32'd1);
    idle(3);

    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_inst", 32'(fw_inst), 32'd0);
      chk("idle_val", 32'(fw_val), 32'd0);
      chk("idle_rdy", 32'(req_ready), 32'd0);
    end

    // Random traffic; commands are held until accepted.
    for (int i = 0; i < 600; i++) begin
      for (int r = 0; r < 2; r++) begin
        if (!req_valid[r] && $urandom_range(0, 2) != 0)
          set_cmd(r, 1'($urandom), $urandom_range(0, 7),
                  1'($urandom));
      end
      step();
      if (m_acc) req_valid[m_who] = 1'b0;
    end
    req_valid = 2'b00;
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end

endmodule
